// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings and instruction field positions for cpu_multicycle_p
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG,
        S_HALT
    } state_t;

    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

    localparam int OPC_HI = 15, OPC_LO = 13;
    localparam int OP_HI  = 12, OP_LO  = 11;
    localparam int RN_HI  = 10, RN_LO  = 8;
    localparam int RD_HI  = 7,  RD_LO  = 5;
    localparam int SH_HI  = 4,  SH_LO  = 3;
    localparam int RM_HI  = 2,  RM_LO  = 0;
    localparam int IMM_HI = 7,  IMM_LO = 0;

endpackage

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - NREG x DATA_W register file, one sync write port, two async read ports
module cpu_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr_a,
    input  logic [2:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [NREG];

    // Indices at or above NREG match no entry: writes vanish, reads return zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we && waddr == i[2:0]) regs[i] <= wdata;
            end
        end
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (raddr_a == i[2:0]) rdata_a = regs[i];
            if (raddr_b == i[2:0]) rdata_b = regs[i];
        end
    end

endmodule

// File: rtl/cpu_multicycle_p.sv
// rtl/cpu_multicycle_p.sv - multicycle MOV/ALU core; CPU_HALT_EN makes opcode 111 a sticky HALT
module cpu_multicycle_p
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              w
);

    state_t            state, state_nx;
    logic [15:0]       ir;
    logic [DATA_W-1:0] a_reg, b_reg, c_reg;
    logic [DATA_W-1:0] rd_a, rd_b, b_sh, alu_out, sximm8, wdata;
    logic [2:0]        opcode, rn, rd, rm, waddr;
    logic [1:0]        op, sh;
    logic [7:0]        imm8;
    logic              we, is_cmp;

    assign opcode = ir[OPC_HI:OPC_LO];
    assign op     = ir[OP_HI:OP_LO];
    assign rn     = ir[RN_HI:RN_LO];
    assign rd     = ir[RD_HI:RD_LO];
    assign sh     = ir[SH_HI:SH_LO];
    assign rm     = ir[RM_HI:RM_LO];
    assign imm8   = ir[IMM_HI:IMM_LO];
    assign sximm8 = {{(DATA_W-8){imm8[7]}}, imm8};
    assign is_cmp = (opcode == OPC_ALU) && (op == OP_CMP);
    assign w      = (state == S_WAIT);
    assign out    = c_reg;

    assign we    = (state == S_WRITE_IMM) || (state == S_WRITE_REG);
    assign waddr = (state == S_WRITE_IMM) ? rn : rd;
    assign wdata = (state == S_WRITE_IMM) ? sximm8 : c_reg;

    cpu_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (rn),
        .raddr_b (rm),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    always_comb begin
        b_sh = b_reg;
        case (sh)
            SH_LSL1: b_sh = {b_reg[DATA_W-2:0], 1'b0};
            SH_LSR1: b_sh = {1'b0, b_reg[DATA_W-1:1]};
            SH_ASR1: b_sh = {b_reg[DATA_W-1], b_reg[DATA_W-1:1]};
            default: b_sh = b_reg;
        endcase
    end

    // MOV reg shares the ADD path with A cleared in GET_B.
    always_comb begin
        alu_out = a_reg + b_sh;
        case (op)
            OP_CMP:  alu_out = a_reg - b_sh;
            OP_AND:  alu_out = a_reg & b_sh;
            OP_MVN:  alu_out = ~b_sh;
            default: alu_out = a_reg + b_sh;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir    <= '0;
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= '0;
            N     <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
        end else begin
            if (load && state == S_WAIT) ir <= in;
            case (state)
                S_GET_A: a_reg <= rd_a;
                S_GET_B: begin
                    b_reg <= rd_b;
                    if (opcode == OPC_MOV) a_reg <= '0;
                end
                S_EXEC: begin
                    c_reg <= alu_out;
                    if (is_cmp) begin
                        Z <= (alu_out == '0);
                        N <= alu_out[DATA_W-1];
                        V <= (a_reg[DATA_W-1] ^ b_sh[DATA_W-1]) &
                             (alu_out[DATA_W-1] ^ a_reg[DATA_W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_WAIT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_WAIT: if (s) state_nx = S_DECODE;
            S_DECODE: begin
                state_nx = S_WAIT;
                if (opcode == OPC_MOV && op == OP_MOV_IMM)      state_nx = S_WRITE_IMM;
                else if (opcode == OPC_MOV && op == OP_MOV_REG) state_nx = S_GET_B;
                else if (opcode == OPC_ALU)                     state_nx = S_GET_A;
`ifdef CPU_HALT_EN
                else if (opcode == OPC_HALT)                    state_nx = S_HALT;
`endif
            end
            S_WRITE_IMM: state_nx = S_WAIT;
            S_GET_A:     state_nx = S_GET_B;
            S_GET_B:     state_nx = S_EXEC;
            S_EXEC:      state_nx = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_nx = S_WAIT;
`ifdef CPU_HALT_EN
            S_HALT:      state_nx = S_HALT;
`endif
            default:     state_nx = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_cpu_multicycle_p.sv
// tb/tb_cpu_multicycle_p.sv - directed vectors for cpu_multicycle_p at 16/8 and 32/4 configurations
module tb_cpu_multicycle_p;

    logic        clk = 1'b0;
    logic        rst16, s16, ld16, N16, V16, Z16, w16;
    logic [15:0] in16, out16;
    logic        rst32, s32, ld32, N32, V32, Z32, w32;
    logic [15:0] in32;
    logic [31:0] out32;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    always #5 clk = ~clk;

    cpu_multicycle_p #(.DATA_W(16), .NREG(8)) dut16 (
        .clk(clk), .reset(rst16), .s(s16), .load(ld16), .in(in16),
        .out(out16), .N(N16), .V(V16), .Z(Z16), .w(w16)
    );

    cpu_multicycle_p #(.DATA_W(32), .NREG(4)) dut32 (
        .clk(clk), .reset(rst32), .s(s32), .load(ld32), .in(in32),
        .out(out32), .N(N32), .V(V32), .Z(Z32), .w(w32)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Loads and starts in the same WAIT cycle, then counts edges (s edge = 1) until w returns.
    task automatic run(input bit big, input logic [15:0] word, input int lat,
                       input bit gate, input string tag);
        int n;
        @(negedge clk);
        if (big) begin in32 = word; ld32 = 1'b1; s32 = 1'b1; end
        else     begin in16 = word; ld16 = 1'b1; s16 = 1'b1; end
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            ld16 = 1'b0; ld32 = 1'b0; s16 = 1'b0; s32 = 1'b0;
            if (gate && n >= 2 && n <= 4) begin in16 = 16'hD0FF; ld16 = 1'b1; end
        end while (!(big ? w32 : w16) && n < 30);
        check({tag, "_lat"}, n, lat);
    endtask

    initial begin
        bit saw_w;
        rst16 = 1'b0; rst32 = 1'b0;
        s16 = 1'b0; ld16 = 1'b0; in16 = '0;
        s32 = 1'b0; ld32 = 1'b0; in32 = '0;
        repeat (2) @(negedge clk);
        check("rst_out16", out16, 0);
        check("rst_flags16", {N16, V16, Z16}, 0);
        check("rst_w16", w16, 1);
        check("rst_out32", out32, 0);
        check("rst_w32", w32, 1);
        rst16 = 1'b1; rst32 = 1'b1;

        run(0, 16'hD007, 3, 0, "mov_r0_7");
        check("movimm_c_hold", out16, 0);
        run(0, 16'hD102, 3, 0, "mov_r1_2");
        run(0, 16'hA148, 6, 1, "add_gated");
        check("add_out", out16, 16'h0010);
        run(0, 16'hA800, 5, 0, "cmp_r0_r0");
        check("cmp0_out", out16, 0);
        check("cmp0_nvz", {N16, V16, Z16}, 3'b001);
        run(0, 16'hA900, 5, 0, "cmp_r1_r0");
        check("cmp1_out", out16, 16'hFFFB);
        check("cmp1_nvz", {N16, V16, Z16}, 3'b100);
        run(0, 16'hC040, 5, 0, "mov_r2_r0");
        check("movreg_out", out16, 16'h0007);
        check("movreg_flag_hold", {N16, V16, Z16}, 3'b100);
        run(0, 16'hD380, 3, 0, "mov_r3_neg");
        run(0, 16'hC093, 5, 0, "mov_lsr");
        check("lsr_out", out16, 16'h7FC0);
        run(0, 16'hC0BB, 5, 0, "mov_asr");
        check("asr_out", out16, 16'hFFC0);
        run(0, 16'hAC03, 5, 0, "cmp_ovf");
        check("ovf_out", out16, 16'h8040);
        check("ovf_nvz", {N16, V16, Z16}, 3'b110);
        run(0, 16'hB4C5, 6, 0, "and");
        check("and_out", out16, 16'h7FC0);
        check("and_flag_hold", {N16, V16, Z16}, 3'b110);

        // Abort an ADD in EXEC with reset; R2 (holding 7) must come back cleared.
        @(negedge clk);
        in16 = 16'hA148; ld16 = 1'b1; s16 = 1'b1;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            ld16 = 1'b0; s16 = 1'b0;
        end
        rst16 = 1'b0;
        #1;
        check("midrst_out", out16, 0);
        check("midrst_w", w16, 1);
        check("midrst_flags", {N16, V16, Z16}, 0);
        @(negedge clk);
        rst16 = 1'b1;
        run(0, 16'hC062, 5, 0, "mov_r3_r2");
        check("midrst_r2", out16, 0);
        run(0, 16'hA148, 6, 0, "add_after_rst");
        check("add_after_rst_out", out16, 0);

        run(1, 16'hD080, 3, 0, "w32_mov_imm");
        run(1, 16'hC020, 5, 0, "w32_mov_r1_r0");
        check("w32_sext", out32, 32'hFFFFFF80);
        run(1, 16'hB800, 6, 0, "w32_mvn");
        check("w32_mvn_out", out32, 32'h0000007F);
        run(1, 16'hC020, 5, 0, "w32_mov_r1_r0b");
        check("w32_r0_after_mvn", out32, 32'h0000007F);
        run(1, 16'hD580, 3, 0, "w32_mov_r5");
        check("w32_movimm_c_hold", out32, 32'h0000007F);
        run(1, 16'hC025, 5, 0, "w32_mov_r1_r5");
        check("w32_r5_reads0", out32, 0);

        run(0, 16'hD045, 3, 0, "mov_r0_45");
        run(0, 16'hC0A0, 5, 0, "mov_r5_r0");
        check("pre_e000_out", out16, 16'h0045);
`ifdef CPU_HALT_EN
        @(negedge clk);
        in16 = 16'hE000; ld16 = 1'b1; s16 = 1'b1;
        saw_w = 1'b0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            s16 = ~s16; ld16 = 1'b1; in16 = 16'hD0FF;
            if (w16) saw_w = 1'b1;
        end
        ld16 = 1'b0; s16 = 1'b0;
        check("halt_w_low", saw_w, 0);
        check("halt_out_hold", out16, 16'h0045);
        rst16 = 1'b0;
        #1;
        check("halt_rst_w", w16, 1);
        @(negedge clk);
        rst16 = 1'b1;
`else
        saw_w = 1'b0;
        run(0, 16'hE000, 2, 0, "undef_111");
        check("undef_out_hold", out16, 16'h0045);
        check("undef_flag_hold", {N16, V16, Z16}, 0);
        run(0, 16'hC0A5, 5, 0, "mov_r5_r5");
        check("undef_reg_hold", out16, 16'h0045);
        check("undef_no_w_drop", saw_w, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
